// File: rtl/lc3b_types.sv
// Shared LC-3b types plus the memory-responder additions (FSM state encoding, bad-read marker).
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } mem_state_t;

  localparam int       MEM_ADDR_W   = 20;
  localparam lc3b_word MEM_BAD_DATA = 16'hDEAD;

  // Request captured at acceptance; only these copies drive the access.
  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    lc3b_word              wdata;
    logic                  we;
    logic                  ub;
    logic                  lb;
  } mem_req_t;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM, 16-bit words with per-byte write enables and a registered read port.
module mem_array
  import lc3b_types::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  we,
  input  logic [1:0]            be,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  lc3b_word              wdata,
  output lc3b_word              rdata
);

  lc3b_word mem [2**DEPTH_LOG2];

  // Reset wins over a write landing on the same edge, so an aborted access never commits.
  always_ff @(posedge clk) begin
    if (en && we && !rst) begin
      if (be[1]) mem[addr][15:8] <= wdata[15:8];
      if (be[0]) mem[addr][7:0]  <= wdata[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// LC-3b memory responder: req/ready handshake with fixed wait-state latency in front of mem_array.
// Build option MEM_BOUNDS_EN adds Mem_err and rejects addresses above the stored range.
//
// state  | meaning
// IDLE   | waiting for Mem_req; latches the request when it is seen
// WAIT   | counting down the wait states
// ACCESS | single cycle RAM access, Mem_ready high
// DONE   | holding result until Mem_req drops; Data_oe high for reads
module mem_responder
  import lc3b_types::*;
#(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [MEM_ADDR_W-1:0] ADDR,
  input  lc3b_word              Data_in,
  input  logic                  Mem_req,
  input  logic                  Mem_we,
  input  logic                  Mem_ub,
  input  logic                  Mem_lb,
  output lc3b_word              Data_out,
  output logic                  Data_oe,
  output logic                  Mem_ready,
  output logic                  Busy
`ifdef MEM_BOUNDS_EN
  ,
  output logic                  Mem_err
`endif
);

  localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

  mem_state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  mem_req_t   req_q;
  logic       req_load;
  logic       addr_bad;
  logic       rd_bad_q;
  lc3b_word   ram_rdata;
  logic       ram_en;
  logic [1:0] ram_be;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= '0;
      req_q    <= '0;
      rd_bad_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (req_load) begin
        req_q <= '{addr: ADDR, wdata: Data_in, we: Mem_we, ub: Mem_ub, lb: Mem_lb};
      end
      if (state == ACCESS && !req_q.we) begin
        rd_bad_q <= addr_bad;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_load  = 1'b0;
    case (state)
      IDLE: begin
        if (Mem_req) begin
          req_load  = 1'b1;
          cnt_nxt   = WS_INIT;
          state_nxt = (WAIT_STATES == 0) ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = ACCESS;
      end
      ACCESS: state_nxt = DONE;
      DONE: begin
        // Mem_req must be seen low before another request can be accepted.
        if (!Mem_req) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef MEM_BOUNDS_EN
  assign addr_bad = |req_q.addr[MEM_ADDR_W-1:DEPTH_LOG2];
  assign Mem_err  = (state == ACCESS) && addr_bad;
`else
  // Upper address bits alias onto the stored range.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_q.addr[MEM_ADDR_W-1:DEPTH_LOG2];
  assign addr_bad       = 1'b0;
`endif

  assign ram_en = (state == ACCESS);
  assign ram_be = {req_q.ub, req_q.lb} & {2{~addr_bad}};

  mem_array #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_mem_array (
    .clk  (Clk),
    .rst  (Reset),
    .en   (ram_en),
    .we   (req_q.we),
    .be   (ram_be),
    .addr (req_q.addr[DEPTH_LOG2-1:0]),
    .wdata(req_q.wdata),
    .rdata(ram_rdata)
  );

  assign Data_out  = rd_bad_q ? MEM_BAD_DATA : ram_rdata;
  assign Data_oe   = (state == DONE) && !req_q.we;
  assign Mem_ready = (state == ACCESS);
  assign Busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance with two wait states, one with none, checked against a word model.
// Define MEM_BOUNDS_EN here as for the RTL to exercise the bounds-error build.
module tb_mem_responder;
  import lc3b_types::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [19:0] addr_s [2];
  lc3b_word    din_s  [2];
  logic        req_s  [2];
  logic        we_s   [2];
  logic        ub_s   [2];
  logic        lb_s   [2];
  lc3b_word    dout_s [2];
  logic        oe_s   [2];
  logic        rdy_s  [2];
  logic        busy_s [2];
`ifdef MEM_BOUNDS_EN
  logic        err_s  [2];
`endif

  int       n_cmp = 0;
  int       n_err = 0;
  lc3b_word exp_q[$];
  lc3b_word model [2][1024];
  int       ws_of [2] = '{2, 0};

  mem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(2)) dut_a (
    .Clk(clk), .Reset(rst), .ADDR(addr_s[0]), .Data_in(din_s[0]),
    .Mem_req(req_s[0]), .Mem_we(we_s[0]), .Mem_ub(ub_s[0]), .Mem_lb(lb_s[0]),
    .Data_out(dout_s[0]), .Data_oe(oe_s[0]), .Mem_ready(rdy_s[0]), .Busy(busy_s[0])
`ifdef MEM_BOUNDS_EN
    , .Mem_err(err_s[0])
`endif
  );

  mem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(0)) dut_b (
    .Clk(clk), .Reset(rst), .ADDR(addr_s[1]), .Data_in(din_s[1]),
    .Mem_req(req_s[1]), .Mem_we(we_s[1]), .Mem_ub(ub_s[1]), .Mem_lb(lb_s[1]),
    .Data_out(dout_s[1]), .Data_oe(oe_s[1]), .Mem_ready(rdy_s[1]), .Busy(busy_s[1])
`ifdef MEM_BOUNDS_EN
    , .Mem_err(err_s[1])
`endif
  );

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input lc3b_word obs, input lc3b_word exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic is_bad(input logic [19:0] a);
`ifdef MEM_BOUNDS_EN
    return |a[19:10];
`else
    return (a === 20'hxxxxx);
`endif
  endfunction

  task automatic check_idle_outputs(input int u, input string tag);
    check_word({tag, "_data_out"}, dout_s[u], 16'h0000);
    check_bit({tag, "_data_oe"}, oe_s[u], 1'b0);
    check_bit({tag, "_ready"}, rdy_s[u], 1'b0);
    check_bit({tag, "_busy"}, busy_s[u], 1'b0);
  endtask

  // One full handshake; inputs are scrambled right after acceptance to prove only latched values matter.
  task automatic xfer(input int u, input logic [19:0] a, input logic we, input logic ub,
                      input logic lb, input lc3b_word d, input int hold);
    int          k;
    lc3b_word    e;
    logic [9:0]  idx;
    idx = a[9:0];
    e   = '0;
    @(negedge clk);
    addr_s[u] = a; din_s[u] = d; we_s[u] = we; ub_s[u] = ub; lb_s[u] = lb; req_s[u] = 1'b1;
    if (we) begin
      if (!is_bad(a)) begin
        if (ub) model[u][idx][15:8] = d[15:8];
        if (lb) model[u][idx][7:0]  = d[7:0];
      end
    end else begin
      exp_q.push_back(is_bad(a) ? MEM_BAD_DATA : model[u][idx]);
    end
    @(posedge clk);
    #1;
    addr_s[u] = ~a; din_s[u] = ~d; we_s[u] = ~we; ub_s[u] = ~ub; lb_s[u] = ~lb;
    k = 0;
    @(negedge clk);
    while (!rdy_s[u] && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_word("ready_latency", 16'(k), 16'(ws_of[u]));
    check_bit("busy_access", busy_s[u], 1'b1);
`ifdef MEM_BOUNDS_EN
    check_bit("err_pulse", err_s[u], is_bad(a));
`endif
    @(negedge clk);
    check_bit("ready_one_cycle", rdy_s[u], 1'b0);
    check_bit("data_oe_done", oe_s[u], !we);
`ifdef MEM_BOUNDS_EN
    check_bit("err_cleared", err_s[u], 1'b0);
`endif
    if (!we) begin
      e = exp_q.pop_front();
      check_word("read_data", dout_s[u], e);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_bit("ready_held_low", rdy_s[u], 1'b0);
      check_bit("busy_held", busy_s[u], 1'b1);
      check_bit("data_oe_held", oe_s[u], !we);
      if (!we) check_word("read_data_held", dout_s[u], e);
    end
    req_s[u] = 1'b0;
    @(negedge clk);
    check_bit("busy_back_idle", busy_s[u], 1'b0);
    check_bit("data_oe_back_idle", oe_s[u], 1'b0);
  endtask

  initial begin
    int k;
    logic [19:0] ra;
    lc3b_word    rd;
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      addr_s[u] = '0; din_s[u] = '0; req_s[u] = 1'b0;
      we_s[u] = 1'b0; ub_s[u] = 1'b0; lb_s[u] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check_idle_outputs(u, "reset");
`ifdef MEM_BOUNDS_EN
      check_bit("reset_err", err_s[u], 1'b0);
`endif
    end
    rst = 1'b0;

    // Write then read back, with Data_oe held for two extra cycles.
    xfer(0, 20'h00010, 1'b1, 1'b1, 1'b1, 16'h1234, 0);
    xfer(0, 20'h00010, 1'b0, 1'b1, 1'b1, 16'h0000, 2);

    // Byte masking.
    xfer(0, 20'h00020, 1'b1, 1'b1, 1'b1, 16'hAAAA, 0);
    xfer(0, 20'h00020, 1'b1, 1'b1, 1'b0, 16'h5566, 0);
    xfer(0, 20'h00020, 1'b0, 1'b0, 1'b0, 16'h0000, 0);
    xfer(0, 20'h00020, 1'b1, 1'b0, 1'b0, 16'h0000, 0);
    xfer(0, 20'h00020, 1'b0, 1'b1, 1'b1, 16'h0000, 0);

    // Mem_req held five cycles past Mem_ready.
    xfer(0, 20'h00010, 1'b0, 1'b0, 1'b0, 16'h0000, 5);

    // Reset while in WAIT aborts the write.
    xfer(0, 20'h00030, 1'b1, 1'b1, 1'b1, 16'h0001, 0);
    @(negedge clk);
    addr_s[0] = 20'h00030; din_s[0] = 16'hBEEF; we_s[0] = 1'b1;
    ub_s[0] = 1'b1; lb_s[0] = 1'b1; req_s[0] = 1'b1;
    @(negedge clk);
    check_bit("wait_busy", busy_s[0], 1'b1);
    check_bit("wait_no_ready", rdy_s[0], 1'b0);
    rst = 1'b1;
    req_s[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_idle_outputs(0, "abort_wait");

    // Reset on the same edge that would commit the write.
    @(negedge clk);
    addr_s[0] = 20'h00030; din_s[0] = 16'hCAFE; we_s[0] = 1'b1;
    ub_s[0] = 1'b1; lb_s[0] = 1'b1; req_s[0] = 1'b1;
    k = 0;
    @(negedge clk);
    while (!rdy_s[0] && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_word("abort_access_latency", 16'(k), 16'd2);
    rst = 1'b1;
    req_s[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_idle_outputs(0, "abort_access");
    xfer(0, 20'h00030, 1'b0, 1'b1, 1'b1, 16'h0000, 0);

    // Out-of-range address: rejected with the bounds option, aliased without it.
    xfer(0, 20'h00000, 1'b1, 1'b1, 1'b1, 16'h1111, 0);
    xfer(0, 20'h00400, 1'b1, 1'b1, 1'b1, 16'h7777, 0);
    xfer(0, 20'h00000, 1'b0, 1'b1, 1'b1, 16'h0000, 0);
`ifdef MEM_BOUNDS_EN
    xfer(0, 20'h00400, 1'b0, 1'b1, 1'b1, 16'h0000, 0);
`endif

    // A few random in-range write/read pairs.
    for (int i = 0; i < 6; i++) begin
      ra = 20'($urandom_range(64, 1023));
      rd = 16'($urandom);
      xfer(0, ra, 1'b1, 1'b1, 1'b1, rd, 0);
      xfer(0, ra, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ~rd, 0);
      xfer(0, ra, 1'b0, 1'b0, 1'b0, 16'h0000, 0);
    end

    // Zero wait states.
    xfer(1, 20'h00044, 1'b1, 1'b1, 1'b1, 16'hC3C3, 0);
    xfer(1, 20'h00044, 1'b0, 1'b1, 1'b1, 16'h0000, 1);
    xfer(1, 20'h00044, 1'b1, 1'b0, 1'b1, 16'h0F0F, 0);
    xfer(1, 20'h00044, 1'b0, 1'b0, 1'b0, 16'h0000, 0);
    check_word("zero_ws_last_read", dout_s[1], 16'hC30F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
